control_flow_sequencer: RTL and testbench
=========================================

// Module: control_flow_sequencer
// PURPOSE
//  Sequences the WASM control stack (frame = {type[1:0], retu_num, sp_tag[3:0], retu_addr[7:0]}) for structured control flow.
//  Accepts one decoded control op at a time (CALL/BLOCK/LOOP/IF/END/BR/RETURN) and drives the stack's push/pop/push_data.
//  Unwinds frames one per cycle for BR/RETURN and emits a one-cycle jump to the decode/PC stage.
//  Frame types: CALL=01, LOOP=11, BLOCK=00, IF=10.
// PARAMETERS
//  FRAME_W  15  frame width; TAG_W + ADDR_W + 3
//  DEPTH    16  control stack depth (frames)
//  LOG_D    4   log2(DEPTH); counter is LOG_D+1 bits
//  ADDR_W   8   return/target address width
//  TAG_W    4   stack-pointer tag width
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        synchronous active-low reset
//  op_valid      in   1        control op offered
//  op_ready      out  1        sequencer can accept op
//  op_code       in   3        0 BLOCK,1 LOOP,2 IF,3 CALL,4 END,5 BR,6 RETURN; 7 illegal
//  op_label      in   LOG_D    BR depth N (0 = innermost frame)
//  op_retu_num   in   1        result count for pushed frame
//  op_sp_tag     in   TAG_W    operand-stack tag for pushed frame
//  op_addr       in   ADDR_W   return/continuation addr for pushed frame
//  cs_push       out  1        stack push strobe
//  cs_pop        out  1        stack pop strobe
//  cs_push_data  out  FRAME_W  frame to push
//  cs_top_data   in   FRAME_W  current top frame (valid when frame_cnt>0)
//  jump_valid    out  1        one-cycle jump pulse
//  jump_addr     out  ADDR_W   jump target (retu_addr of target frame)
//  jump_sp_tag   out  TAG_W    sp_tag of target frame
//  jump_retu_num out  1        retu_num of target frame
//  frame_cnt     out  LOG_D+1  frames currently on stack
//  err           out  1        sticky: overflow/underflow/bad label/illegal op
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE, frame_cnt=0, err=0, jump_valid=0, jump_* =0; cs_push/cs_pop=0. Stack shares rst_n.
//  cs_push/cs_pop/cs_push_data combinational from state, accept and cs_top_data; never both high in one cycle.
//  States: IDLE, UNWIND_BR, UNWIND_RET, ERR. op_ready=1 only in IDLE; accept = op_valid & op_ready.
//  IDLE, BLOCK/LOOP/IF/CALL: frame_cnt<DEPTH -> cs_push same cycle, data {type,op_retu_num,op_sp_tag,op_addr}; cnt+1.
//    frame_cnt==DEPTH -> no push, err=1, go ERR.
//  IDLE, END: frame_cnt==0 -> ERR. Else cs_pop same cycle, cnt-1; top type CALL -> jump_valid next cycle with its fields.
//  IDLE, BR: op_label>=frame_cnt -> ERR, no pop. Else latch remaining=op_label, go UNWIND_BR (no pop in accept cycle).
//  UNWIND_BR each cycle: remaining>0 -> pop, remaining-1. remaining==0 -> target=top; LOOP: no pop; else pop;
//    register jump from target next cycle; go IDLE. BR N: N+1 UNWIND cycles; jump_valid in the first IDLE cycle.
//  IDLE, RETURN: frame_cnt==0 -> ERR; else go UNWIND_RET.
//  UNWIND_RET each cycle: frame_cnt==0 -> ERR. Else pop top; type CALL -> jump next cycle, go IDLE; else stay.
//  Illegal op_code (7) accepted -> ERR. ERR: op_ready=0, no push/pop, err held until reset.
//  jump_valid is high exactly one cycle; jump_* hold last target otherwise. Op may be accepted in the jump_valid cycle.
//  frame_cnt tracks every push/pop exactly (never wraps). Reset mid-unwind -> IDLE, cnt 0, no jump.
// TESTING
//  T1 reset; CALL addr=0x40,tag=3 then END -> push then pop; jump_valid 1 cycle later, jump_addr=0x40, jump_sp_tag=3, cnt=0.
//  T2 CALL(0x10),BLOCK(0x20),BLOCK(0x30); BR 1 -> 2 pops over 2 cycles; jump_addr=0x20; cnt=1; op_ready low 2 cycles.
//  T3 CALL,LOOP(0x55),BLOCK; BR 1 -> 1 pop; LOOP kept; jump_addr=0x55; cnt=2.
//  T4 CALL(0x11),BLOCK,IF,LOOP; RETURN -> 4 pops over 4 cycles; jump_addr=0x11; cnt=0.
//  T5 16 pushes then BLOCK -> no push, err=1, op_ready=0; BR 5 with cnt=3 -> err; END at cnt=0 -> err.
//  T6 rst_n low during UNWIND_RET -> next cycle IDLE, cnt=0, jump_valid=0, err=0.

Source files
------------

// File: rtl/control_flow_sequencer_if.sv
// Purpose : bundles the control-op handshake, control-stack strobes and jump
//           outputs of the control flow sequencer into one port.
// Ports   : master = op source / stack side, slave = sequencer side.
interface control_flow_sequencer_if #(
  parameter int FRAME_W = 15,
  parameter int LOG_D   = 4,
  parameter int ADDR_W  = 8,
  parameter int TAG_W   = 4
);
  // decoded control op handshake
  logic               op_valid;
  logic               op_ready;
  logic [2:0]         op_code;
  logic [LOG_D-1:0]   op_label;
  logic               op_retu_num;
  logic [TAG_W-1:0]   op_sp_tag;
  logic [ADDR_W-1:0]  op_addr;
  // control stack
  logic               cs_push;
  logic               cs_pop;
  logic [FRAME_W-1:0] cs_push_data;
  logic [FRAME_W-1:0] cs_top_data;
  // jump to decode/PC stage and status
  logic               jump_valid;
  logic [ADDR_W-1:0]  jump_addr;
  logic [TAG_W-1:0]   jump_sp_tag;
  logic               jump_retu_num;
  logic [LOG_D:0]     frame_cnt;
  logic               err;

  modport master (
    output op_valid, op_code, op_label, op_retu_num, op_sp_tag, op_addr, cs_top_data,
    input  op_ready, cs_push, cs_pop, cs_push_data,
    input  jump_valid, jump_addr, jump_sp_tag, jump_retu_num, frame_cnt, err
  );

  modport slave (
    input  op_valid, op_code, op_label, op_retu_num, op_sp_tag, op_addr, cs_top_data,
    output op_ready, cs_push, cs_pop, cs_push_data,
    output jump_valid, jump_addr, jump_sp_tag, jump_retu_num, frame_cnt, err
  );
endinterface

// File: rtl/control_flow_sequencer.sv
// Purpose     : sequences the WASM control stack for BLOCK/LOOP/IF/CALL/END/BR/RETURN.
// Latency     : push/pop in the accept cycle; BR N unwinds N+1 cycles, RETURN one frame per cycle; jump registered.
// Backpressure: op_ready only in IDLE; low while unwinding and forever once an error is flagged.
// Ports: clk, rst_n (sync, active low); bus.slave carries op handshake, stack
//        push/pop/push_data/top_data, jump pulse + target fields, frame_cnt, err.
module control_flow_sequencer #(
  parameter int FRAME_W = 15,
  parameter int DEPTH   = 16,
  parameter int LOG_D   = 4,
  parameter int ADDR_W  = 8,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  control_flow_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_UNWIND_BR, S_UNWIND_RET, S_ERR} state_t;

  localparam logic [1:0] T_BLOCK = 2'b00;
  localparam logic [1:0] T_CALL  = 2'b01;
  localparam logic [1:0] T_IF    = 2'b10;
  localparam logic [1:0] T_LOOP  = 2'b11;

  localparam logic [LOG_D:0]   CNT_MAX = (LOG_D+1)'(DEPTH);
  localparam logic [LOG_D:0]   CNT_ONE = (LOG_D+1)'(1);
  localparam logic [LOG_D-1:0] REM_ONE = LOG_D'(1);

  state_t             state_q, state_d;
  logic [LOG_D:0]     cnt_q, cnt_d;
  logic [LOG_D-1:0]   rem_q, rem_d;
  logic               err_q, err_d;
  logic               jv_q, jv_d;
  logic [ADDR_W-1:0]  ja_q, ja_d;
  logic [TAG_W-1:0]   jt_q, jt_d;
  logic               jr_q, jr_d;

  logic               push, pop, ready, take_jump, go_err;
  logic [1:0]         push_type;

  // top frame fields: {type, retu_num, sp_tag, retu_addr}
  logic [1:0]         top_type;
  logic               top_rn;
  logic [TAG_W-1:0]   top_tag;
  logic [ADDR_W-1:0]  top_addr;

  assign top_type = bus.cs_top_data[FRAME_W-1 -: 2];
  assign top_rn   = bus.cs_top_data[ADDR_W+TAG_W];
  assign top_tag  = bus.cs_top_data[ADDR_W +: TAG_W];
  assign top_addr = bus.cs_top_data[ADDR_W-1:0];

  always_comb begin
    case (bus.op_code[1:0])
      2'd0:    push_type = T_BLOCK;
      2'd1:    push_type = T_LOOP;
      2'd2:    push_type = T_IF;
      default: push_type = T_CALL;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    err_d     = err_q;
    jv_d      = 1'b0;
    ja_d      = ja_q;
    jt_d      = jt_q;
    jr_d      = jr_q;
    push      = 1'b0;
    pop       = 1'b0;
    ready     = 1'b0;
    take_jump = 1'b0;
    go_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.op_valid) begin
          case (bus.op_code)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              if (cnt_q < CNT_MAX) begin
                push  = 1'b1;
                cnt_d = cnt_q + CNT_ONE;
              end else begin
                go_err = 1'b1;
              end
            end
            3'd4: begin
              if (cnt_q == '0) begin
                go_err = 1'b1;
              end else begin
                pop       = 1'b1;
                cnt_d     = cnt_q - CNT_ONE;
                take_jump = (top_type == T_CALL);
              end
            end
            3'd5: begin
              // label must name an existing frame; unwinding starts next cycle
              if ({1'b0, bus.op_label} >= cnt_q) begin
                go_err = 1'b1;
              end else begin
                rem_d   = bus.op_label;
                state_d = S_UNWIND_BR;
              end
            end
            3'd6: begin
              if (cnt_q == '0) go_err = 1'b1;
              else             state_d = S_UNWIND_RET;
            end
            default: go_err = 1'b1;
          endcase
        end
      end

      S_UNWIND_BR: begin
        if (rem_q != '0) begin
          pop   = 1'b1;
          cnt_d = cnt_q - CNT_ONE;
          rem_d = rem_q - REM_ONE;
        end else begin
          // branch target: a LOOP stays on the stack (re-entered), others are exited
          take_jump = 1'b1;
          state_d   = S_IDLE;
          if (top_type != T_LOOP) begin
            pop   = 1'b1;
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      S_UNWIND_RET: begin
        if (cnt_q == '0) begin
          go_err = 1'b1;
        end else begin
          pop   = 1'b1;
          cnt_d = cnt_q - CNT_ONE;
          if (top_type == T_CALL) begin
            take_jump = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end

      default: ;  // S_ERR: frozen until reset
    endcase

    if (go_err) begin
      err_d   = 1'b1;
      state_d = S_ERR;
    end

    if (take_jump) begin
      jv_d = 1'b1;
      ja_d = top_addr;
      jt_d = top_tag;
      jr_d = top_rn;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      jv_q    <= 1'b0;
      ja_q    <= '0;
      jt_q    <= '0;
      jr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      jv_q    <= jv_d;
      ja_q    <= ja_d;
      jt_q    <= jt_d;
      jr_q    <= jr_d;
    end
  end

  assign bus.op_ready      = ready;
  assign bus.cs_push       = push;
  assign bus.cs_pop        = pop;
  assign bus.cs_push_data  = {push_type, bus.op_retu_num, bus.op_sp_tag, bus.op_addr};
  assign bus.jump_valid    = jv_q;
  assign bus.jump_addr     = ja_q;
  assign bus.jump_sp_tag   = jt_q;
  assign bus.jump_retu_num = jr_q;
  assign bus.frame_cnt     = cnt_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_control_flow_sequencer.sv
// Purpose     : self-checking bench for control_flow_sequencer with a frame-queue reference model.
// Latency     : each op is driven, then the bench waits (bounded) for op_ready or err before checking.
// Backpressure: ops are only offered while the sequencer is idle.
module tb_control_flow_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  control_flow_sequencer_if bus();

  control_flow_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [1:0] ty;
    logic       rn;
    logic [3:0] tag;
    logic [7:0] addr;
  } frame_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- control stack environment ----------------
  logic [14:0] stk [16];
  logic [4:0]  sp;
  logic [4:0]  spm1;
  assign spm1 = sp - 5'd1;
  always_comb bus.cs_top_data = (sp != 5'd0) ? stk[spm1[3:0]] : 15'd0;

  always @(posedge clk) begin
    if (!rst_n) sp <= 5'd0;
    else if (bus.cs_push && sp < 5'd16) begin
      stk[sp[3:0]] <= bus.cs_push_data;
      sp <= sp + 5'd1;
    end else if (bus.cs_pop && sp != 5'd0) sp <= sp - 5'd1;
  end

  // ---------------- monitors ----------------
  int jcnt    = 0;
  bit pp_both = 1'b0;
  bit pp_err  = 1'b0;
  always @(negedge clk) begin
    if (bus.jump_valid) jcnt++;
    if (bus.cs_push && bus.cs_pop) pp_both = 1'b1;
    if (bus.err && (bus.cs_push || bus.cs_pop)) pp_err = 1'b1;
  end

  // ---------------- reference model ----------------
  frame_t mq[$];
  int     exp_jtotal = 0;

  function automatic logic [1:0] ty_of(input logic [2:0] code);
    case (code)
      3'd0:    return 2'b00;
      3'd1:    return 2'b11;
      3'd2:    return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_cnt",  32'(bus.frame_cnt), 0);
    chk("rst_err",  32'(bus.err), 0);
    chk("rst_jv",   32'(bus.jump_valid), 0);
    chk("rst_rdy",  32'(bus.op_ready), 1);
    chk("rst_jadr", 32'(bus.jump_addr), 0);
    chk("rst_jtag", 32'(bus.jump_sp_tag), 0);
    chk("rst_pop",  32'(bus.cs_pop), 0);
    rst_n = 1'b1;
    mq.delete();
  endtask

  // Called at a sample point (#1 after a rising edge) with the DUT idle.
  task automatic do_op(input logic [2:0] code, input logic [3:0] lbl, input logic rn,
                       input logic [3:0] tag, input logic [7:0] addr);
    bit     e_err = 1'b0;
    bit     e_jmp = 1'b0;
    int     e_busy = 0;
    int     busy = 0;
    int     guard = 0;
    frame_t f;
    frame_t jf = '0;

    case (code)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        if (mq.size() == 16) e_err = 1'b1;
        else begin
          f = {ty_of(code), rn, tag, addr};
          mq.push_back(f);
        end
      end
      3'd4: begin
        if (mq.size() == 0) e_err = 1'b1;
        else begin
          f = mq.pop_back();
          if (f.ty == 2'b01) begin e_jmp = 1'b1; jf = f; end
        end
      end
      3'd5: begin
        if (int'(lbl) >= mq.size()) e_err = 1'b1;
        else begin
          repeat (int'(lbl)) void'(mq.pop_back());
          jf = mq[$];
          if (jf.ty != 2'b11) void'(mq.pop_back());
          e_jmp  = 1'b1;
          e_busy = int'(lbl) + 1;
        end
      end
      3'd6: begin
        if (mq.size() == 0) e_err = 1'b1;
        else begin
          while (1) begin
            if (mq.size() == 0) begin e_err = 1'b1; break; end
            f = mq.pop_back();
            e_busy++;
            if (f.ty == 2'b01) begin e_jmp = 1'b1; jf = f; break; end
          end
        end
      end
      default: e_err = 1'b1;
    endcase
    if (e_jmp) exp_jtotal++;

    bus.op_valid    = 1'b1;
    bus.op_code     = code;
    bus.op_label    = lbl;
    bus.op_retu_num = rn;
    bus.op_sp_tag   = tag;
    bus.op_addr     = addr;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;

    while (!bus.op_ready && !bus.err && guard < 64) begin
      busy++;
      guard++;
      @(posedge clk); #1;
    end
    if (guard >= 64) chk("timeout", 32'(guard), 0);

    chk("err", 32'(bus.err), 32'(e_err));
    chk("cnt", 32'(bus.frame_cnt), 32'(mq.size()));
    if (e_err) begin
      chk("rdy_in_err", 32'(bus.op_ready), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("err_held", 32'(bus.err), 1);
      chk("cnt_held", 32'(bus.frame_cnt), 32'(mq.size()));
      do_reset();
    end else begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("jv", 32'(bus.jump_valid), 32'(e_jmp));
      if (e_jmp) begin
        chk("jaddr", 32'(bus.jump_addr), 32'(jf.addr));
        chk("jtag",  32'(bus.jump_sp_tag), 32'(jf.tag));
        chk("jrn",   32'(bus.jump_retu_num), 32'(jf.rn));
      end
      if (mq.size() > 0) chk("top", 32'(bus.cs_top_data), 32'(mq[$]));
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.op_valid    = 1'b0;
    bus.op_code     = 3'd0;
    bus.op_label    = 4'd0;
    bus.op_retu_num = 1'b0;
    bus.op_sp_tag   = 4'd0;
    bus.op_addr     = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // T1: CALL then END
    do_op(3'd3, 4'd0, 1'b1, 4'd3, 8'h40);
    do_op(3'd4, 4'd0, 1'b0, 4'd0, 8'h00);
    chk("t1_addr", 32'(bus.jump_addr), 32'h40);
    chk("t1_tag",  32'(bus.jump_sp_tag), 3);

    // T2: CALL, BLOCK, BLOCK; BR 1
    do_op(3'd3, 4'd0, 1'b0, 4'd1, 8'h10);
    do_op(3'd0, 4'd0, 1'b1, 4'd2, 8'h20);
    do_op(3'd0, 4'd0, 1'b0, 4'd3, 8'h30);
    do_op(3'd5, 4'd1, 1'b0, 4'd0, 8'h00);
    chk("t2_addr", 32'(bus.jump_addr), 32'h20);
    chk("t2_cnt",  32'(bus.frame_cnt), 1);

    // T3: CALL, LOOP, BLOCK; BR 1 keeps the LOOP
    do_reset();
    do_op(3'd3, 4'd0, 1'b0, 4'd1, 8'h01);
    do_op(3'd1, 4'd0, 1'b1, 4'd5, 8'h55);
    do_op(3'd0, 4'd0, 1'b0, 4'd6, 8'h66);
    do_op(3'd5, 4'd1, 1'b0, 4'd0, 8'h00);
    chk("t3_addr", 32'(bus.jump_addr), 32'h55);
    chk("t3_cnt",  32'(bus.frame_cnt), 2);

    // T4: CALL, BLOCK, IF, LOOP; RETURN
    do_reset();
    do_op(3'd3, 4'd0, 1'b1, 4'd7, 8'h11);
    do_op(3'd0, 4'd0, 1'b0, 4'd1, 8'h22);
    do_op(3'd2, 4'd0, 1'b0, 4'd2, 8'h33);
    do_op(3'd1, 4'd0, 1'b0, 4'd3, 8'h44);
    do_op(3'd6, 4'd0, 1'b0, 4'd0, 8'h00);
    chk("t4_addr", 32'(bus.jump_addr), 32'h11);
    chk("t4_cnt",  32'(bus.frame_cnt), 0);

    // T5: overflow, bad label, underflow, illegal op
    for (int i = 0; i < 16; i++) do_op(3'(i % 4), 4'd0, 1'b0, 4'(i), 8'(i * 3));
    do_op(3'd0, 4'd0, 1'b0, 4'd0, 8'h99);
    for (int i = 0; i < 3; i++) do_op(3'd0, 4'd0, 1'b0, 4'd0, 8'(i));
    do_op(3'd5, 4'd5, 1'b0, 4'd0, 8'h00);
    do_op(3'd4, 4'd0, 1'b0, 4'd0, 8'h00);
    do_op(3'd7, 4'd0, 1'b0, 4'd0, 8'h00);

    // T6: reset in the middle of a RETURN unwind
    do_op(3'd3, 4'd0, 1'b0, 4'd1, 8'hA0);
    do_op(3'd0, 4'd0, 1'b0, 4'd2, 8'hB0);
    do_op(3'd0, 4'd0, 1'b0, 4'd3, 8'hC0);
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd6;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk("t6_busy", 32'(bus.op_ready), 0);
    do_reset();
    @(posedge clk); #1;
    chk("t6_jv_after", 32'(bus.jump_valid), 0);

    // randomized op stream
    for (int n = 0; n < 500; n++) begin
      int          r;
      int          lim;
      logic [2:0]  code;
      logic [3:0]  lbl;
      r    = $urandom_range(0, 99);
      lim  = (mq.size() > 15) ? 15 : mq.size();
      lbl  = 4'($urandom_range(0, lim));
      if (r < 45)      code = 3'($urandom_range(0, 3));
      else if (r < 60) code = 3'd4;
      else if (r < 75) code = 3'd5;
      else if (r < 88) code = 3'd6;
      else if (r < 90) code = 3'd7;
      else             code = 3'($urandom_range(0, 3));
      do_op(code, lbl, 1'($urandom), 4'($urandom), 8'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("jump_total", 32'(jcnt), 32'(exp_jtotal));
    chk("push_pop_both", 32'(pp_both), 0);
    chk("strobe_in_err", 32'(pp_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
